alu_issue_stage: RTL and testbench

//  Upstream issue/capture stage wrapped around the combinational 4-bit ALU (ALU_4_bit).
//  - Buffers operand/opcode commands in a small FIFO.
//  - Drives the ALU a/b/s inputs from the FIFO head.
//  - Registers the ALU's y/carry/zero into a result slot with a valid/ready handshake.

---
 rtl/alu_issue_pkg.sv | 10 +
 rtl/alu_issue_if.sv | 45 ++++
 rtl/alu_cmd_fifo.sv | 36 +++
 rtl/alu_issue_stage.sv | 68 ++++++
 tb/tb_alu_issue_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared widths and the command record for the ALU issue stage.
package alu_issue_pkg;
   localparam int OP_W = 3;
   localparam int DATA_W = 4;
   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [OP_W-1:0]   op;
   } cmd_t;
endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: command, ALU and result signals of the issue stage.
// carry_cnt exists only when CARRY_COUNT_EN is defined.
interface alu_issue_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
);
   import alu_issue_pkg::*;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [WIDTH-1:0]       cmd_a;
   logic [WIDTH-1:0]       cmd_b;
   logic [OP_W-1:0]        cmd_op;
   logic [WIDTH-1:0]       alu_a;
   logic [WIDTH-1:0]       alu_b;
   logic [OP_W-1:0]        alu_s;
   logic [WIDTH-1:0]       alu_y;
   logic                   alu_carry;
   logic                   alu_zero;
   logic                   res_valid;
   logic                   res_ready;
   logic [WIDTH-1:0]       res_y;
   logic                   res_carry;
   logic                   res_zero;
   logic [OP_W-1:0]        res_op;
   logic [$clog2(DEPTH):0] fifo_level;
`ifdef CARRY_COUNT_EN
   logic [7:0]             carry_cnt;
`endif
   modport slave (
`ifdef CARRY_COUNT_EN
      output carry_cnt,
`endif
      input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_y, alu_carry, alu_zero, res_ready,
      output cmd_ready, alu_a, alu_b, alu_s, res_valid, res_y, res_carry, res_zero, res_op,
             fifo_level
   );
   modport master (
`ifdef CARRY_COUNT_EN
      input  carry_cnt,
`endif
      output cmd_valid, cmd_a, cmd_b, cmd_op, alu_y, alu_carry, alu_zero, res_ready,
      input  cmd_ready, alu_a, alu_b, alu_s, res_valid, res_y, res_carry, res_zero, res_op,
             fifo_level
   );
endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: DEPTH-entry synchronous FIFO reporting level, full and empty.
module alu_cmd_fifo #(
   parameter int DW = 11,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DW-1:0]          wdata,
   output logic [DW-1:0]          rdata,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   always_ff @(posedge clk)
      if (push) mem[wp] <= wdata;
   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         level <= level + LW'(push) - LW'(pop);
      end
   assign rdata = mem[rp];
   assign full  = level == LW'(DEPTH);
   assign empty = level == '0;
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: command FIFO feeding an external combinational ALU, with a registered
// valid/ready result slot. Defining CARRY_COUNT_EN adds a saturating carry_cnt output.
module alu_issue_stage
   import alu_issue_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input logic        clk,
   input logic        rst_n,
   alu_issue_if.slave bus
);
   localparam int DW = 2 * WIDTH + OP_W;
   logic                   full, empty, push, issue;
   logic [DW-1:0]          head;
   logic [$clog2(DEPTH):0] level;
   logic                   res_valid, res_carry, res_zero;
   logic [WIDTH-1:0]       res_y;
   logic [OP_W-1:0]        res_op;
   // A full FIFO refuses commands even when the head pops on the same edge.
   assign push  = bus.cmd_valid && !full;
   assign issue = !empty && (!res_valid || bus.res_ready);
   alu_cmd_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (issue),
      .wdata ({bus.cmd_a, bus.cmd_b, bus.cmd_op}),
      .rdata (head),
      .level (level),
      .full  (full),
      .empty (empty)
   );
   assign bus.alu_a      = empty ? '0 : head[DW-1 -: WIDTH];
   assign bus.alu_b      = empty ? '0 : head[OP_W +: WIDTH];
   assign bus.alu_s      = empty ? '0 : head[OP_W-1:0];
   assign bus.cmd_ready  = !full;
   assign bus.fifo_level = level;
   // The slot refills on the same edge it drains, giving one result per cycle.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_y     <= '0;
         res_carry <= 1'b0;
         res_zero  <= 1'b0;
         res_op    <= '0;
      end else if (issue) begin
         res_valid <= 1'b1;
         res_y     <= bus.alu_y;
         res_carry <= bus.alu_carry;
         res_zero  <= bus.alu_zero;
         res_op    <= bus.alu_s;
      end else if (bus.res_ready) begin
         res_valid <= 1'b0;
      end
   assign bus.res_valid = res_valid;
   assign bus.res_y     = res_y;
   assign bus.res_carry = res_carry;
   assign bus.res_zero  = res_zero;
   assign bus.res_op    = res_op;
`ifdef CARRY_COUNT_EN
   logic [7:0] carry_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) carry_cnt <= '0;
      else if (issue && bus.alu_carry && carry_cnt != 8'hFF) carry_cnt <= carry_cnt + 8'd1;
   assign bus.carry_cnt = carry_cnt;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: stand-in 4-bit ALU on the alu_* pins plus a queue scoreboard of results.
module tb_alu_issue_stage;
   import alu_issue_pkg::*;
   typedef struct packed {
      logic [3:0] y;
      logic       c;
      logic       z;
      logic [2:0] op;
   } res_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errs = 0;
   int   checks = 0;
   int   cnt_model = 0;
   res_t exp_q[$];
   res_t got_q[$];
   res_t alu_r;
   always #5 clk = ~clk;
   alu_issue_if #(.WIDTH(4), .DEPTH(4)) bus ();
   alu_issue_stage #(.WIDTH(4), .DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   // add, sub(borrow), and, or, xor, not a, shl, shr; carry holds the shifted-out bit
   function automatic res_t alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      int   ia, ib, r;
      logic c;
      res_t o;
      ia = int'(a);
      ib = int'(b);
      c = 1'b0;
      r = 0;
      case (op)
         3'd0: begin r = ia + ib; c = r > 15; end
         3'd1: begin r = ia - ib; c = r < 0; end
         3'd2: r = int'(a & b);
         3'd3: r = int'(a | b);
         3'd4: r = int'(a ^ b);
         3'd5: r = 15 - ia;
         3'd6: begin r = ia * 2; c = ia >= 8; end
         default: begin r = ia / 2; c = (ia % 2) == 1; end
      endcase
      o.y = 4'(r);
      o.c = c;
      o.z = o.y == 4'd0;
      o.op = op;
      return o;
   endfunction
   assign alu_r         = alu_f(bus.alu_a, bus.alu_b, bus.alu_s);
   assign bus.alu_y     = alu_r.y;
   assign bus.alu_carry = alu_r.c;
   assign bus.alu_zero  = alu_r.z;
   always @(negedge clk)
      if (rst_n) begin
         if (bus.cmd_valid && bus.cmd_ready) begin
            exp_q.push_back(alu_f(bus.cmd_a, bus.cmd_b, bus.cmd_op));
            if (alu_f(bus.cmd_a, bus.cmd_b, bus.cmd_op).c) cnt_model++;
         end
         if (bus.res_valid && bus.res_ready)
            got_q.push_back({bus.res_y, bus.res_carry, bus.res_zero, bus.res_op});
      end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic v, input cmd_t c);
      bus.cmd_valid = v;
      bus.cmd_a = c.a;
      bus.cmd_b = c.b;
      bus.cmd_op = c.op;
   endtask
   function automatic cmd_t rnd_cmd();
      cmd_t c;
      c.a = 4'($urandom);
      c.b = 4'($urandom);
      c.op = 3'($urandom);
      return c;
   endfunction
   task automatic test_reset;
      rst_n = 1'b0;
      bus.res_ready = 1'b0;
      drive(1'b0, cmd_t'(0));
      repeat (3) tick();
      checks++; if (bus.res_valid !== 1'b0) begin errs++; $display("FAIL reset_res_valid got=%0b exp=0", bus.res_valid); end
      checks++; if (bus.fifo_level !== 3'd0) begin errs++; $display("FAIL reset_level got=%0d exp=0", bus.fifo_level); end
      checks++; if (bus.alu_s !== 3'd0) begin errs++; $display("FAIL reset_alu_s got=%0d exp=0", bus.alu_s); end
      checks++; if (bus.res_y !== 4'd0 || bus.res_op !== 3'd0) begin errs++; $display("FAIL reset_res got=%h/%h exp=0/0", bus.res_y, bus.res_op); end
      rst_n = 1'b1;
      #1;
      checks++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_cmd_ready got=%0b exp=1", bus.cmd_ready); end
   endtask
   task automatic test_single;
      bus.res_ready = 1'b1;
      drive(1'b1, cmd_t'{4'b1010, 4'b0101, 3'b000});
      tick();
      drive(1'b0, cmd_t'(0));
      checks++; if (bus.res_valid !== 1'b0) begin errs++; $display("FAIL single_early got=%0b exp=0", bus.res_valid); end
      checks++; if (bus.fifo_level !== 3'd1) begin errs++; $display("FAIL single_level got=%0d exp=1", bus.fifo_level); end
      checks++; if (bus.alu_a !== 4'b1010 || bus.alu_b !== 4'b0101) begin errs++; $display("FAIL single_alu_ab got=%b/%b exp=1010/0101", bus.alu_a, bus.alu_b); end
      tick();
      checks++; if (bus.res_valid !== 1'b1) begin errs++; $display("FAIL single_valid got=%0b exp=1", bus.res_valid); end
      checks++; if ({bus.res_y, bus.res_carry, bus.res_zero, bus.res_op} !== {4'b1111, 1'b0, 1'b0, 3'b000})
         begin errs++; $display("FAIL single_result got=%b/%b/%b/%b exp=1111/0/0/000", bus.res_y, bus.res_carry, bus.res_zero, bus.res_op); end
      tick();
      checks++; if (bus.res_valid !== 1'b0) begin errs++; $display("FAIL single_drain got=%0b exp=0", bus.res_valid); end
      exp_q.delete();
      got_q.delete();
   endtask
   task automatic test_backpressure;
      bus.res_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, rnd_cmd());
         tick();
      end
      drive(1'b0, cmd_t'(0));
      checks++; if (bus.cmd_ready !== 1'b0) begin errs++; $display("FAIL bp_cmd_ready got=%0b exp=0", bus.cmd_ready); end
      checks++; if (bus.fifo_level !== 3'd4) begin errs++; $display("FAIL bp_level got=%0d exp=4", bus.fifo_level); end
      checks++; if (exp_q.size() != 5) begin errs++; $display("FAIL bp_accepted got=%0d exp=5", exp_q.size()); end
      bus.res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (bus.res_valid !== (i < 4)) begin errs++; $display("FAIL bp_stream[%0d] got=%0b exp=%0b", i, bus.res_valid, i < 4); end
      end
      checks++; if (got_q.size() != exp_q.size()) begin errs++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL bp_result[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete();
      got_q.delete();
   endtask
   task automatic test_sweep;
      int mx;
      mx = 0;
      bus.res_ready = 1'b1;
      for (int op = 0; op < 8; op++) begin
         drive(1'b1, cmd_t'{4'b1010, 4'b0101, 3'(op)});
         tick();
         if (int'(bus.fifo_level) > mx) mx = int'(bus.fifo_level);
      end
      drive(1'b0, cmd_t'(0));
      for (int k = 0; k < 20 && got_q.size() < 8; k++) tick();
      checks++; if (mx != 1) begin errs++; $display("FAIL sweep_max_level got=%0d exp=1", mx); end
      checks++; if (got_q.size() != 8) begin errs++; $display("FAIL sweep_count got=%0d exp=8", got_q.size()); end
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== alu_f(4'b1010, 4'b0101, 3'(i))) begin errs++; $display("FAIL sweep_result[%0d] got=%h exp=%h", i, got_q[i], alu_f(4'b1010, 4'b0101, 3'(i))); end
      end
      exp_q.delete();
      got_q.delete();
   endtask
   task automatic test_random;
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(3) != 0, rnd_cmd());
         bus.res_ready = $urandom_range(2) != 0;
         tick();
      end
      drive(1'b0, cmd_t'(0));
      bus.res_ready = 1'b1;
      for (int k = 0; k < 20 && (bus.res_valid || bus.fifo_level != 0); k++) tick();
      checks++; if (bus.res_valid !== 1'b0 || bus.fifo_level !== 3'd0) begin errs++; $display("FAIL rnd_drain got=%0b/%0d exp=0/0", bus.res_valid, bus.fifo_level); end
      checks++; if (got_q.size() != exp_q.size()) begin errs++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL rnd_result[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete();
      got_q.delete();
   endtask
   task automatic test_reset_mid;
      bus.res_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, cmd_t'{4'b1111, 4'b0001, 3'b001});
         tick();
      end
      drive(1'b0, cmd_t'(0));
      checks++; if (bus.res_valid !== 1'b1 || bus.fifo_level !== 3'd2) begin errs++; $display("FAIL mid_pre got=%0b/%0d exp=1/2", bus.res_valid, bus.fifo_level); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.res_valid !== 1'b0 || bus.fifo_level !== 3'd0) begin errs++; $display("FAIL mid_async got=%0b/%0d exp=0/0", bus.res_valid, bus.fifo_level); end
      checks++; if (bus.alu_a !== 4'd0 || bus.alu_b !== 4'd0 || bus.alu_s !== 3'd0) begin errs++; $display("FAIL mid_alu got=%h/%h/%h exp=0/0/0", bus.alu_a, bus.alu_b, bus.alu_s); end
      checks++; if (bus.res_y !== 4'd0 || bus.res_op !== 3'd0 || bus.res_carry !== 1'b0) begin errs++; $display("FAIL mid_res got=%h/%h/%b exp=0/0/0", bus.res_y, bus.res_op, bus.res_carry); end
      exp_q.delete();
      got_q.delete();
      cnt_model = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      bus.res_ready = 1'b1;
      repeat (5) tick();
      checks++; if (got_q.size() != 0 || bus.res_valid !== 1'b0) begin errs++; $display("FAIL mid_stale got=%0d/%0b exp=0/0", got_q.size(), bus.res_valid); end
   endtask
`ifdef CARRY_COUNT_EN
   task automatic test_carry_count;
      int n[4] = '{10, 10, 290, 10};
      int want;
      checks++; if (bus.carry_cnt !== 8'd0) begin errs++; $display("FAIL cc_reset got=%0d exp=0", bus.carry_cnt); end
      bus.res_ready = 1'b1;
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < n[p]; i++) begin
            drive(1'b1, (p == 0 || p == 3) ? cmd_t'{4'($urandom), 4'($urandom), 3'd2} : cmd_t'{4'hF, 4'h1, 3'd0});
            tick();
         end
         drive(1'b0, cmd_t'(0));
         for (int k = 0; k < 20 && (bus.res_valid || bus.fifo_level != 0); k++) tick();
         want = cnt_model > 255 ? 255 : cnt_model;
         checks++; if (bus.carry_cnt !== 8'(want)) begin errs++; $display("FAIL cc_phase%0d got=%0d exp=%0d", p, bus.carry_cnt, want); end
      end
      exp_q.delete();
      got_q.delete();
   endtask
`endif
   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end
   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_sweep();
      test_random();
      test_reset_mid();
`ifdef CARRY_COUNT_EN
      test_carry_count();
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
